axil_reg_file: RTL and testbench
================================

// Module: axil_reg_file
// PURPOSE
// AXI-Lite slave register file directly downstream of udp_axil_bridge: terminates its AXIL_IF master port.
// Exposes NUM_CTRL read/write control registers to fabric logic and NUM_STATUS read-only status registers from it.
// Gives the UDP host register-level control and observation of the design.
// Returns OKAY, SLVERR or DECERR so the bridge can report WRITE_OK/READ_OK per request.
// PARAMETERS
// NUM_CTRL          8             number of RW control registers, 1..64
// NUM_STATUS        8             number of RO status registers, 1..64
// CTRL_RESET_VALUE  32'h0000_0000 reset value of every control register
// PORTS
// clk            in   1                  system clock
// reset          in   1                  synchronous, active-high reset
// axil_if        --   AXIL_IF.Slave      32-bit addr/data AXI-Lite slave (aw/w/b/ar/r channels)
// ctrl_regs      out  [NUM_CTRL][32]     current control register values
// ctrl_wr_pulse  out  [NUM_CTRL]         1-cycle pulse on the cycle a control register is updated
// status_regs    in   [NUM_STATUS][32]   status values; sampled on the AR handshake edge
// BEHAVIOUR
// - Clock/reset: one clock (clk); reset synchronous, active-high.
// - Reset values:
//   - ctrl_regs = CTRL_RESET_VALUE; ctrl_wr_pulse = 0.
//   - awready = wready = arready = 1; bvalid = rvalid = 0; bresp = rresp = OKAY; rdata = 0.
// - Address map (byte address, word aligned): idx = addr[31:2]; addr[1:0] ignored.
//   - idx < NUM_CTRL: control register, RW.
//   - NUM_CTRL <= idx < NUM_CTRL+NUM_STATUS: status register, RO.
//   - All other idx: unmapped.
// - Write path: AW and W are captured independently, in either order or in the same cycle.
//   - awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
//   - Commit edge: first edge with aw_held && w_held.
//     - CTRL index: byte lanes with wstrb[i]=1 update; ctrl_wr_pulse[idx] = 1 for exactly that cycle; bresp = OKAY.
//     - STATUS index: no update, no pulse; bresp = SLVERR.
//     - Unmapped index: no update, no pulse; bresp = DECERR.
//     - At the same edge: bvalid <= 1; aw_held, w_held cleared.
//   - bvalid holds until bready; awready/wready return high the cycle after the B handshake.
//   - Minimum write turnaround: AW+W handshake -> bvalid 1 cycle later -> B handshake.
//   - wstrb == 0 on a CTRL index: OKAY response, pulse still asserted, value unchanged.
// - Read path: arready = !rvalid.
//   - AR handshake edge: rdata <= selected register (live status_regs value), rvalid <= 1.
//   - rresp: OKAY for ctrl/status indices; DECERR with rdata = 32'hDEAD_BEEF for unmapped.
//   - rvalid holds with rdata stable until rready. Latency 1 cycle; one read per 2 cycles max.
// - Read and write channels are fully independent and may complete in the same cycle.
// - Read of a control register whose write commits on the same edge returns the OLD value.
// - arprot/awprot are accepted and ignored.
// - Reset mid-transaction: held AW/W and pending B/R are discarded; all outputs return to reset values next edge.
// STRUCTURE
// - Shared package axil_reg_file_pkg:
//   - reg_kind_t enum {REG_CTRL, REG_STATUS, REG_UNMAPPED}.
//   - function decode(idx) -> reg_kind_t.
//   - localparam UNMAPPED_RDATA = 32'hDEAD_BEEF.
// - No sub-module: write join, decode and read mux are inline (~200 lines).
// TESTING
// - Reset, then AW+W to 0x04 data 0x1234_5678 wstrb 4'hF -> bresp OKAY; ctrl_regs[1] = 0x1234_5678; ctrl_wr_pulse[1] high 1 cycle.
// - W (0xAAAA_BBBB, wstrb 4'b0011) 3 cycles before AW 0x00 -> wready low while held; ctrl_regs[0] = 0x0000_BBBB; single B.
// - status_regs[0] = 0xCAFE_0001, AR addr 4*NUM_CTRL -> rvalid 1 cycle later, rdata 0xCAFE_0001, rresp OKAY; hold rready low 5 cycles -> rdata stable.
// - Write to status address -> SLVERR, ctrl unchanged; AR/AW at 4*(NUM_CTRL+NUM_STATUS) -> DECERR, rdata 0xDEAD_BEEF.
// - Same-cycle write 0x5 commit and read of ctrl[2] (old 0x0) -> rdata 0x0; next read -> 0x5. bready low 10 cycles -> awready stays low.
// - Assert reset with AW held and rvalid pending -> next cycle bvalid = rvalid = 0, ready signals high, ctrl_regs = CTRL_RESET_VALUE.

Source files
------------

// File: rtl/axil_reg_file_pkg.sv
// Shared types, response codes and address decode for the AXI-Lite register file.
package axil_reg_file_pkg;

    typedef enum logic [1:0] {
        REG_CTRL,
        REG_STATUS,
        REG_UNMAPPED
    } reg_kind_t;

    localparam logic [1:0]  RESP_OKAY      = 2'b00;
    localparam logic [1:0]  RESP_SLVERR    = 2'b10;
    localparam logic [1:0]  RESP_DECERR    = 2'b11;
    localparam logic [31:0] UNMAPPED_RDATA = 32'hDEAD_BEEF;

    // Control registers occupy the low word indices, status registers follow directly after.
    function automatic reg_kind_t decode(input logic [29:0] idx,
                                         input int unsigned num_ctrl,
                                         input int unsigned num_status);
        logic [31:0] wide;
        wide = {2'b00, idx};
        if (wide < num_ctrl)
            return REG_CTRL;
        else if (wide < num_ctrl + num_status)
            return REG_STATUS;
        else
            return REG_UNMAPPED;
    endfunction

endpackage

// File: rtl/axil_if.sv
// 32-bit AXI-Lite bus bundle shared between udp_axil_bridge and axil_reg_file.
interface AXIL_IF;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport Master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport Slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axil_reg_file.sv
// AXI-Lite slave exposing RW control registers to the fabric and RO status registers from it.
module axil_reg_file
    import axil_reg_file_pkg::*;
#(
    parameter int unsigned NUM_CTRL         = 8,
    parameter int unsigned NUM_STATUS       = 8,
    parameter logic [31:0] CTRL_RESET_VALUE = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         reset,
    AXIL_IF.Slave                        axil_if,
    output logic [NUM_CTRL-1:0][31:0]    ctrl_regs,
    output logic [NUM_CTRL-1:0]          ctrl_wr_pulse,
    input  logic [NUM_STATUS-1:0][31:0]  status_regs
);

    logic        aw_held;
    logic        w_held;
    logic [29:0] aw_idx;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        bvalid;
    logic [1:0]  bresp;
    logic        rvalid;
    logic [1:0]  rresp;
    logic [31:0] rdata;

    logic        awready;
    logic        wready;
    logic        arready;
    logic        commit;
    reg_kind_t   wr_kind;
    reg_kind_t   rd_kind;
    logic [31:0] rd_value;
    logic        unused_bits;

    assign awready = !aw_held && !bvalid;
    assign wready  = !w_held && !bvalid;
    assign arready = !rvalid;
    assign commit  = aw_held && w_held;
    assign wr_kind = decode(aw_idx, NUM_CTRL, NUM_STATUS);

    assign axil_if.awready = awready;
    assign axil_if.wready  = wready;
    assign axil_if.bvalid  = bvalid;
    assign axil_if.bresp   = bresp;
    assign axil_if.arready = arready;
    assign axil_if.rvalid  = rvalid;
    assign axil_if.rresp   = rresp;
    assign axil_if.rdata   = rdata;

    // Protection bits and the byte offset within a word carry no meaning here.
    assign unused_bits = ^{axil_if.awprot, axil_if.arprot, axil_if.awaddr[1:0], axil_if.araddr[1:0]};

    always_comb begin
        rd_kind  = decode(axil_if.araddr[31:2], NUM_CTRL, NUM_STATUS);
        rd_value = UNMAPPED_RDATA;
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (axil_if.araddr[31:2] == 30'(i))
                rd_value = ctrl_regs[i];
        end
        for (int i = 0; i < NUM_STATUS; i++) begin
            if (axil_if.araddr[31:2] == 30'(NUM_CTRL + i))
                rd_value = status_regs[i];
        end
    end

    // AW and W are parked independently; the write lands on the first edge both are held.
    always_ff @(posedge clk) begin
        if (reset) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_idx        <= '0;
            w_data        <= '0;
            w_strb        <= '0;
            bvalid        <= 1'b0;
            bresp         <= RESP_OKAY;
            ctrl_regs     <= {NUM_CTRL{CTRL_RESET_VALUE}};
            ctrl_wr_pulse <= '0;
        end else begin
            ctrl_wr_pulse <= '0;
            if (axil_if.awvalid && awready) begin
                aw_held <= 1'b1;
                aw_idx  <= axil_if.awaddr[31:2];
            end
            if (axil_if.wvalid && wready) begin
                w_held <= 1'b1;
                w_data <= axil_if.wdata;
                w_strb <= axil_if.wstrb;
            end
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                case (wr_kind)
                    REG_CTRL: begin
                        bresp <= RESP_OKAY;
                        for (int i = 0; i < NUM_CTRL; i++) begin
                            if (aw_idx == 30'(i)) begin
                                ctrl_wr_pulse[i] <= 1'b1;
                                for (int b = 0; b < 4; b++) begin
                                    if (w_strb[b])
                                        ctrl_regs[i][8*b +: 8] <= w_data[8*b +: 8];
                                end
                            end
                        end
                    end
                    REG_STATUS: bresp <= RESP_SLVERR;
                    default:    bresp <= RESP_DECERR;
                endcase
            end else if (bvalid && axil_if.bready) begin
                bvalid <= 1'b0;
            end
        end
    end

    // Read data is captured at the AR handshake and frozen until the R handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid <= 1'b0;
            rresp  <= RESP_OKAY;
            rdata  <= '0;
        end else if (axil_if.arvalid && arready) begin
            rvalid <= 1'b1;
            rdata  <= rd_value;
            rresp  <= (rd_kind == REG_UNMAPPED) ? RESP_DECERR : RESP_OKAY;
        end else if (rvalid && axil_if.rready) begin
            rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axil_reg_file.sv
// Directed self-checking bench for axil_reg_file with 8 control and 8 status registers.
module tb_axil_reg_file;

    localparam int NC = 8;
    localparam int NS = 8;

    logic                  clk;
    logic                  reset;
    logic [NC-1:0][31:0]   ctrl_regs;
    logic [NC-1:0]         ctrl_wr_pulse;
    logic [NS-1:0][31:0]   status_regs;

    int vectors;
    int miscompares;

    AXIL_IF bus();

    axil_reg_file #(
        .NUM_CTRL(NC),
        .NUM_STATUS(NS),
        .CTRL_RESET_VALUE(32'h0000_0000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .axil_if(bus),
        .ctrl_regs(ctrl_regs),
        .ctrl_wr_pulse(ctrl_wr_pulse),
        .status_regs(status_regs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives AW and W together (slave must be ready), waits for B and accepts it.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output bit ok);
        bus.awvalid = 1'b1;
        bus.awaddr  = addr;
        bus.wvalid  = 1'b1;
        bus.wdata   = data;
        bus.wstrb   = strb;
        step();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.bvalid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        resp = bus.bresp;
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                            output bit ok);
        bus.arvalid = 1'b1;
        bus.araddr  = addr;
        step();
        bus.arvalid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.rvalid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        data = bus.rdata;
        resp = bus.rresp;
        bus.rready = 1'b1;
        step();
        bus.rready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        vectors++;
        if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
            miscompares++;
            $display("[TB] FAIL reset_ready: got %b expected 111", {bus.awready, bus.wready, bus.arready});
        end
        vectors++;
        if ({bus.bvalid, bus.rvalid} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL reset_valid: got %b expected 00", {bus.bvalid, bus.rvalid});
        end
        vectors++;
        if ({bus.bresp, bus.rresp} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_resp: got %b expected 0000", {bus.bresp, bus.rresp});
        end
        vectors++;
        if (bus.rdata !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_rdata: got %h expected 00000000", bus.rdata);
        end
        vectors++;
        if (ctrl_regs !== '0 || ctrl_wr_pulse !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: got %h/%b expected all zero", ctrl_regs, ctrl_wr_pulse);
        end
        reset = 1'b0;
        step();
        vectors++;
        if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b11100) begin
            miscompares++;
            $display("[TB] FAIL post_reset_idle: got %b expected 11100",
                     {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
        end
    endtask

    task automatic test_basic_write();
        bus.awvalid = 1'b1;
        bus.awaddr  = 32'h04;
        bus.wvalid  = 1'b1;
        bus.wdata   = 32'h1234_5678;
        bus.wstrb   = 4'hF;
        step();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        vectors++;
        if ({bus.awready, bus.wready, bus.bvalid, ctrl_wr_pulse} !== {3'b000, 8'h00}) begin
            miscompares++;
            $display("[TB] FAIL write_held: got aw/w/b=%b pulse=%b expected 000 pulse=0",
                     {bus.awready, bus.wready, bus.bvalid}, ctrl_wr_pulse);
        end
        step();
        vectors++;
        if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL write_b: got bvalid=%b bresp=%b expected 1/00", bus.bvalid, bus.bresp);
        end
        vectors++;
        if (ctrl_regs[1] !== 32'h1234_5678) begin
            miscompares++;
            $display("[TB] FAIL write_ctrl1: got %h expected 12345678", ctrl_regs[1]);
        end
        vectors++;
        if (ctrl_wr_pulse !== 8'h02) begin
            miscompares++;
            $display("[TB] FAIL write_pulse_on: got %b expected 00000010", ctrl_wr_pulse);
        end
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
        vectors++;
        if (ctrl_wr_pulse !== 8'h00 || bus.bvalid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL write_pulse_off: got pulse=%b bvalid=%b expected 0/0", ctrl_wr_pulse, bus.bvalid);
        end
        vectors++;
        if ({bus.awready, bus.wready} !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL write_ready_back: got %b expected 11", {bus.awready, bus.wready});
        end
    endtask

    task automatic test_w_before_aw();
        bus.wvalid = 1'b1;
        bus.wdata  = 32'hAAAA_BBBB;
        bus.wstrb  = 4'b0011;
        step();
        bus.wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (bus.wready !== 1'b0 || bus.bvalid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL w_held_cycle%0d: got wready=%b bvalid=%b expected 0/0", i, bus.wready, bus.bvalid);
            end
            if (i < 2) step();
        end
        bus.awvalid = 1'b1;
        bus.awaddr  = 32'h00;
        step();
        bus.awvalid = 1'b0;
        step();
        vectors++;
        if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00 || ctrl_regs[0] !== 32'h0000_BBBB) begin
            miscompares++;
            $display("[TB] FAIL w_first_commit: got bvalid=%b bresp=%b ctrl0=%h expected 1/00/0000bbbb",
                     bus.bvalid, bus.bresp, ctrl_regs[0]);
        end
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
        step();
        vectors++;
        if (bus.bvalid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL w_first_single_b: got bvalid=%b expected 0", bus.bvalid);
        end
    endtask

    task automatic test_status_read();
        status_regs[0] = 32'hCAFE_0001;
        bus.arvalid = 1'b1;
        bus.araddr  = 32'(4 * NC);
        step();
        bus.arvalid = 1'b0;
        status_regs[0] = 32'h1111_2222;
        vectors++;
        if (bus.rvalid !== 1'b1 || bus.rdata !== 32'hCAFE_0001 || bus.rresp !== 2'b00 || bus.arready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL status_read: got rvalid=%b rdata=%h rresp=%b arready=%b expected 1/cafe0001/00/0",
                     bus.rvalid, bus.rdata, bus.rresp, bus.arready);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if (bus.rvalid !== 1'b1 || bus.rdata !== 32'hCAFE_0001) begin
                miscompares++;
                $display("[TB] FAIL rdata_stable%0d: got rvalid=%b rdata=%h expected 1/cafe0001", i, bus.rvalid, bus.rdata);
            end
        end
        bus.rready = 1'b1;
        step();
        bus.rready = 1'b0;
        vectors++;
        if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL read_release: got rvalid=%b arready=%b expected 0/1", bus.rvalid, bus.arready);
        end
    endtask

    task automatic test_errors();
        logic [1:0]  resp;
        logic [31:0] data;
        bit          ok;
        axi_write(32'(4 * NC), 32'hFFFF_FFFF, 4'hF, resp, ok);
        vectors++;
        if (!ok || resp !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL status_write_resp: got ok=%0d bresp=%b expected 1/10", ok, resp);
        end
        vectors++;
        if (ctrl_regs[0] !== 32'h0000_BBBB || ctrl_regs[1] !== 32'h1234_5678) begin
            miscompares++;
            $display("[TB] FAIL status_write_noupdate: got %h/%h expected 0000bbbb/12345678", ctrl_regs[0], ctrl_regs[1]);
        end
        axi_write(32'(4 * (NC + NS)), 32'h0BAD_0BAD, 4'hF, resp, ok);
        vectors++;
        if (!ok || resp !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL unmapped_write_resp: got ok=%0d bresp=%b expected 1/11", ok, resp);
        end
        axi_read(32'(4 * (NC + NS)), data, resp, ok);
        vectors++;
        if (!ok || resp !== 2'b11 || data !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("[TB] FAIL unmapped_read: got ok=%0d rresp=%b rdata=%h expected 1/11/deadbeef", ok, resp, data);
        end
        status_regs[NS-1] = 32'h7777_8888;
        axi_read(32'(4 * (NC + NS - 1)), data, resp, ok);
        vectors++;
        if (!ok || resp !== 2'b00 || data !== 32'h7777_8888) begin
            miscompares++;
            $display("[TB] FAIL last_status_read: got ok=%0d rresp=%b rdata=%h expected 1/00/77778888", ok, resp, data);
        end
        axi_read(32'h0000_0007, data, resp, ok);
        vectors++;
        if (!ok || resp !== 2'b00 || data !== 32'h1234_5678) begin
            miscompares++;
            $display("[TB] FAIL unaligned_read: got ok=%0d rresp=%b rdata=%h expected 1/00/12345678", ok, resp, data);
        end
        axi_write(32'(4 * (NC - 1)), 32'h1122_3344, 4'b1010, resp, ok);
        vectors++;
        if (!ok || resp !== 2'b00 || ctrl_regs[NC-1] !== 32'h1100_3300) begin
            miscompares++;
            $display("[TB] FAIL byte_lanes: got ok=%0d bresp=%b ctrl7=%h expected 1/00/11003300", ok, resp, ctrl_regs[NC-1]);
        end
    endtask

    task automatic test_wstrb_zero();
        bus.awvalid = 1'b1;
        bus.awaddr  = 32'h0C;
        bus.wvalid  = 1'b1;
        bus.wdata   = 32'hFFFF_FFFF;
        bus.wstrb   = 4'h0;
        step();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        step();
        vectors++;
        if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00 || ctrl_wr_pulse !== 8'h08 || ctrl_regs[3] !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL wstrb_zero: got bvalid=%b bresp=%b pulse=%b ctrl3=%h expected 1/00/00001000/00000000",
                     bus.bvalid, bus.bresp, ctrl_wr_pulse, ctrl_regs[3]);
        end
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [1:0]  resp;
        logic [31:0] data;
        bit          ok;
        bus.awvalid = 1'b1;
        bus.awaddr  = 32'h08;
        bus.wvalid  = 1'b1;
        bus.wdata   = 32'h0000_0005;
        bus.wstrb   = 4'hF;
        step();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.arvalid = 1'b1;
        bus.araddr  = 32'h08;
        step();
        bus.arvalid = 1'b0;
        vectors++;
        if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h0 || bus.bvalid !== 1'b1 || ctrl_regs[2] !== 32'h5) begin
            miscompares++;
            $display("[TB] FAIL same_edge_read: got rvalid=%b rdata=%h bvalid=%b ctrl2=%h expected 1/00000000/1/00000005",
                     bus.rvalid, bus.rdata, bus.bvalid, ctrl_regs[2]);
        end
        bus.rready = 1'b1;
        step();
        bus.rready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (bus.awready !== 1'b0 || bus.wready !== 1'b0 || bus.bvalid !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL b_backpressure%0d: got awready=%b wready=%b bvalid=%b expected 0/0/1",
                         i, bus.awready, bus.wready, bus.bvalid);
            end
            step();
        end
        axi_read(32'h08, data, resp, ok);
        vectors++;
        if (!ok || resp !== 2'b00 || data !== 32'h5) begin
            miscompares++;
            $display("[TB] FAIL reread_ctrl2: got ok=%0d rresp=%b rdata=%h expected 1/00/00000005", ok, resp, data);
        end
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
        vectors++;
        if (bus.bvalid !== 1'b0 || bus.awready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b_release: got bvalid=%b awready=%b expected 0/1", bus.bvalid, bus.awready);
        end
    endtask

    task automatic test_reset_mid();
        bus.awvalid = 1'b1;
        bus.awaddr  = 32'h04;
        bus.arvalid = 1'b1;
        bus.araddr  = 32'h04;
        step();
        bus.awvalid = 1'b0;
        bus.arvalid = 1'b0;
        vectors++;
        if (bus.awready !== 1'b0 || bus.rvalid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mid_setup: got awready=%b rvalid=%b expected 0/1", bus.awready, bus.rvalid);
        end
        reset = 1'b1;
        step();
        vectors++;
        if ({bus.bvalid, bus.rvalid, bus.awready, bus.wready, bus.arready} !== 5'b00111 || bus.rdata !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_handshake: got b/r/aw/w/ar=%b rdata=%h expected 00111/00000000",
                     {bus.bvalid, bus.rvalid, bus.awready, bus.wready, bus.arready}, bus.rdata);
        end
        vectors++;
        if (ctrl_regs !== '0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_ctrl: got %h expected all zero", ctrl_regs);
        end
        reset = 1'b0;
        bus.wvalid = 1'b1;
        bus.wdata  = 32'h5555_5555;
        bus.wstrb  = 4'hF;
        step();
        bus.wvalid = 1'b0;
        step();
        step();
        vectors++;
        if (bus.bvalid !== 1'b0 || ctrl_regs[1] !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL aw_discarded: got bvalid=%b ctrl1=%h expected 0/00000000", bus.bvalid, ctrl_regs[1]);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        status_regs = '0;
        bus.awvalid = 1'b0;
        bus.awaddr  = '0;
        bus.awprot  = 3'b000;
        bus.wvalid  = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.bready  = 1'b0;
        bus.arvalid = 1'b0;
        bus.araddr  = '0;
        bus.arprot  = 3'b000;
        bus.rready  = 1'b0;

        test_reset();
        test_basic_write();
        test_w_before_aw();
        test_status_read();
        test_errors();
        test_wstrb_zero();
        test_back_to_back();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
